rv32i_multicycle_sequencer: RTL and testbench

RV32I_MULTICYCLE_SEQUENCER -- requirements
Module: rv32i_multicycle_sequencer

---
 rtl/rv32i_multicycle_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_rv32i_multicycle_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives
// the datapath strobes for each step. A memory handshake that waits too long,
// or an illegal opcode, parks the block in TRAP.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, halt           start fetch from IDLE/TRAP; return to IDLE at next retirement
//   opcode                instruction bits [6:0] from the instruction register
//   imem_ready/dmem_ready memory completion handshakes
//   branch_taken          ALU compare result
//   imem_req .. rf_we     datapath strobes; pc_we/pc_sel update the PC
//   busy, retire_pulse    status; retire_count is the retired-instruction count
//   trap_cause, state     trap reason and current FSM state
module rv32i_multicycle_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  input  logic [6:0]  opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        busy,
  output logic        retire_pulse,
  output logic [1:0]  pc_sel,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state,
  output logic [31:0] retire_count
);

  localparam int unsigned WAIT_W = 8;
  // A wait cycle that finds the counter here is the last one allowed.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SEL_PC4    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_REG, C_IMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_ILLEGAL
  } class_e;

  // Opcode class decode.
  function automatic class_e decode_class(input logic [6:0] op);
    case (op)
      7'b0110011: decode_class = C_REG;
      7'b0010011: decode_class = C_IMM;
      7'b0000011: decode_class = C_LOAD;
      7'b0100011: decode_class = C_STORE;
      7'b1100011: decode_class = C_BRANCH;
      7'b1101111: decode_class = C_JAL;
      7'b1100111: decode_class = C_JALR;
      default:    decode_class = C_ILLEGAL;
    endcase
  endfunction

  state_e            state_q, state_d;
  class_e            cls_q, cls_d;
  class_e            dec_cls;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       retire_cnt_q;

  assign dec_cls      = decode_class(opcode);
  assign state        = state_q;
  assign trap_cause   = cause_q;
  assign retire_count = retire_cnt_q;

  // State, latched class, wait counter, trap cause and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cls_q        <= C_ILLEGAL;
      wait_q       <= '0;
      cause_q      <= CAUSE_NONE;
      retire_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (retire_pulse) begin
        retire_cnt_q <= retire_cnt_q + 32'd1;
      end
    end
  end

  // Next state and strobes. Request strobes depend on state only; ir_we and
  // the retire outputs follow the ready/halt inputs in the same cycle.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    wait_d       = wait_q;
    cause_d      = cause_q;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = SEL_PC4;
    retire_pulse = 1'b0;
    busy         = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end

      S_FETCH: begin
        imem_req = 1'b1;
        // Ready on the last allowed wait cycle still wins over the timeout.
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        if (dec_cls == C_ILLEGAL) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          cls_d   = dec_cls;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (cls_q)
          C_BRANCH: begin
            pc_we        = 1'b1;
            pc_sel       = branch_taken ? SEL_BRANCH : SEL_PC4;
            retire_pulse = 1'b1;
          end
          C_LOAD, C_STORE: begin
            state_d = S_MEM;
            wait_d  = '0;
          end
          default: state_d = S_WB;
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if (dmem_ready) begin
          if (cls_q == C_STORE) begin
            pc_we        = 1'b1;
            retire_pulse = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        rf_we        = 1'b1;
        pc_we        = 1'b1;
        pc_sel       = (cls_q == C_JAL || cls_q == C_JALR) ? SEL_JUMP : SEL_PC4;
        retire_pulse = 1'b1;
      end

      S_TRAP: begin
        if (start) begin
          cause_d = CAUSE_NONE;
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Every retirement either stops on halt or starts the next fetch.
    if (retire_pulse) begin
      state_d = halt ? S_IDLE : S_FETCH;
      wait_d  = '0;
    end
  end

endmodule

// File: tb/tb_rv32i_multicycle_sequencer.sv
// Directed bench for rv32i_multicycle_sequencer: a cycle-by-cycle vector table
// plus hand sequences for reset abort and retire counter wrap.
module tb_rv32i_multicycle_sequencer;

  localparam int unsigned TMO = 4;

  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ILL   = 7'b1111111;

  // {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, busy, retire_pulse}
  localparam logic [7:0] ZZ    = 8'b0000_0000;
  localparam logic [7:0] BZ    = 8'b0000_0010;
  localparam logic [7:0] FE    = 8'b1000_0010;
  localparam logic [7:0] FE_IR = 8'b1100_0010;
  localparam logic [7:0] MEM_L = 8'b0010_0010;
  localparam logic [7:0] MEM_S = 8'b0011_0010;
  localparam logic [7:0] MEM_R = 8'b0011_0111;
  localparam logic [7:0] WBR   = 8'b0000_1111;
  localparam logic [7:0] BRR   = 8'b0000_0111;

  typedef struct {
    logic       start;
    logic       halt;
    logic [6:0] opcode;
    logic       imem_ready;
    logic       dmem_ready;
    logic       branch_taken;
    logic [2:0] e_state;
    logic [7:0] e_strb;
    logic [1:0] e_sel;
    logic [1:0] e_cause;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, halt, imem_ready, dmem_ready, branch_taken;
  logic [6:0]  opcode;
  logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, busy, retire_pulse;
  logic [1:0]  pc_sel, trap_cause;
  logic [2:0]  state;
  logic [31:0] retire_count;
  logic [7:0]  strb;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt;
  vec_t        vq[$];

  assign strb = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, busy, retire_pulse};

  rv32i_multicycle_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .pc_we(pc_we), .busy(busy), .retire_pulse(retire_pulse),
    .pc_sel(pc_sel), .trap_cause(trap_cause), .state(state), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic h, input logic [6:0] op,
                              input logic ir, input logic dr, input logic bt,
                              input logic [2:0] es, input logic [7:0] eb,
                              input logic [1:0] esel, input logic [1:0] ec);
    vec_t v;
    v.start = s; v.halt = h; v.opcode = op;
    v.imem_ready = ir; v.dmem_ready = dr; v.branch_taken = bt;
    v.e_state = es; v.e_strb = eb; v.e_sel = esel; v.e_cause = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic h, input logic [6:0] op,
                       input logic ir, input logic dr, input logic bt);
    start = s; halt = h; opcode = op;
    imem_ready = ir; dmem_ready = dr; branch_taken = bt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // start halt op  ir dr bt  state strobes sel cause
    vq.push_back(mk(0,0,OP_REG,  0,0,0, 3'd0, ZZ,    2'd0, 2'd0)); // 0 idle
    vq.push_back(mk(1,0,OP_REG,  0,0,0, 3'd0, ZZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_REG,  1,0,0, 3'd1, FE_IR, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_REG,  0,0,0, 3'd2, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_ILL,  0,0,0, 3'd3, BZ,    2'd0, 2'd0)); // opcode change after decode ignored
    vq.push_back(mk(0,0,OP_ILL,  0,0,0, 3'd5, WBR,   2'd0, 2'd0)); // 5 REG retire
    vq.push_back(mk(0,0,OP_JAL,  1,0,0, 3'd1, FE_IR, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_JAL,  0,0,0, 3'd2, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_JAL,  0,0,0, 3'd3, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_JAL,  0,0,0, 3'd5, WBR,   2'd2, 2'd0)); // 9 JAL retire
    vq.push_back(mk(0,0,OP_LOAD, 1,0,0, 3'd1, FE_IR, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_LOAD, 0,0,0, 3'd2, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_LOAD, 0,0,0, 3'd3, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_LOAD, 0,0,0, 3'd4, MEM_L, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_LOAD, 0,0,0, 3'd4, MEM_L, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_LOAD, 0,0,0, 3'd4, MEM_L, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_LOAD, 0,1,0, 3'd4, MEM_L, 2'd0, 2'd0)); // ready on last allowed cycle
    vq.push_back(mk(0,0,OP_LOAD, 0,0,0, 3'd5, WBR,   2'd0, 2'd0)); // 17 LOAD retire
    vq.push_back(mk(0,0,OP_STORE,1,0,0, 3'd1, FE_IR, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_STORE,0,0,0, 3'd2, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_STORE,0,0,0, 3'd3, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_STORE,0,0,0, 3'd4, MEM_S, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_STORE,0,0,0, 3'd4, MEM_S, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_STORE,0,0,0, 3'd4, MEM_S, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_STORE,0,1,0, 3'd4, MEM_R, 2'd0, 2'd0)); // 24 STORE retire
    vq.push_back(mk(0,0,OP_BR,   1,0,0, 3'd1, FE_IR, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_BR,   0,0,0, 3'd2, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_BR,   0,0,1, 3'd3, BRR,   2'd1, 2'd0)); // 27 taken
    vq.push_back(mk(0,0,OP_BR,   1,0,0, 3'd1, FE_IR, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_BR,   0,0,0, 3'd2, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_BR,   0,0,0, 3'd3, BRR,   2'd0, 2'd0)); // 30 not taken
    vq.push_back(mk(0,0,OP_ILL,  1,0,0, 3'd1, FE_IR, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_ILL,  0,0,0, 3'd2, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_ILL,  0,0,0, 3'd6, BZ,    2'd0, 2'd1)); // illegal trap
    vq.push_back(mk(1,0,OP_ILL,  0,0,0, 3'd6, BZ,    2'd0, 2'd1));
    vq.push_back(mk(0,0,OP_IMM,  0,0,0, 3'd1, FE,    2'd0, 2'd0)); // cause cleared
    vq.push_back(mk(0,0,OP_IMM,  0,0,0, 3'd1, FE,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_IMM,  0,0,0, 3'd1, FE,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_IMM,  1,0,0, 3'd1, FE_IR, 2'd0, 2'd0)); // ready on 4th wait cycle
    vq.push_back(mk(0,0,OP_IMM,  0,0,0, 3'd2, BZ,    2'd0, 2'd0));
    vq.push_back(mk(1,1,OP_IMM,  0,0,0, 3'd3, BZ,    2'd0, 2'd0)); // start/halt ignored here
    vq.push_back(mk(0,1,OP_IMM,  0,0,0, 3'd5, WBR,   2'd0, 2'd0)); // 41 halt at retire
    vq.push_back(mk(1,0,OP_IMM,  0,0,0, 3'd0, ZZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_IMM,  0,0,0, 3'd1, FE,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_IMM,  0,0,0, 3'd1, FE,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_IMM,  0,0,0, 3'd1, FE,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_IMM,  0,0,0, 3'd1, FE,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_IMM,  0,0,0, 3'd6, BZ,    2'd0, 2'd2)); // imem timeout
    vq.push_back(mk(1,0,OP_IMM,  0,0,0, 3'd6, BZ,    2'd0, 2'd2));
    vq.push_back(mk(0,0,OP_LOAD, 1,0,0, 3'd1, FE_IR, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_LOAD, 0,0,0, 3'd2, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_LOAD, 0,0,0, 3'd3, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_LOAD, 0,0,0, 3'd4, MEM_L, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_LOAD, 0,0,0, 3'd4, MEM_L, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_LOAD, 0,0,0, 3'd4, MEM_L, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_LOAD, 0,0,0, 3'd4, MEM_L, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_LOAD, 0,0,0, 3'd6, BZ,    2'd0, 2'd3)); // dmem timeout
    vq.push_back(mk(1,0,OP_LOAD, 0,0,0, 3'd6, BZ,    2'd0, 2'd3));
    vq.push_back(mk(0,0,OP_JALR, 1,0,0, 3'd1, FE_IR, 2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_JALR, 0,0,0, 3'd2, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,0,OP_JALR, 0,0,0, 3'd3, BZ,    2'd0, 2'd0));
    vq.push_back(mk(0,1,OP_JALR, 0,0,0, 3'd5, WBR,   2'd2, 2'd0)); // 61 JALR retire + halt
    vq.push_back(mk(0,0,OP_JALR, 0,0,0, 3'd0, ZZ,    2'd0, 2'd0));

    // Reset state
    rst = 1'b1;
    drive(0,0,OP_REG,0,0,0);
    tick(); tick();
    check("reset_ctl", 64'({state, strb, pc_sel, trap_cause}), 64'd0);
    check("reset_cnt", 64'(retire_count), 64'd0);
    rst = 1'b0;

    // Vector table, one row per clock
    exp_cnt = 32'd0;
    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].halt, vq[i].opcode,
            vq[i].imem_ready, vq[i].dmem_ready, vq[i].branch_taken);
      @(negedge clk);
      check($sformatf("row%0d_ctl", i), 64'({state, strb, pc_sel, trap_cause}),
            64'({vq[i].e_state, vq[i].e_strb, vq[i].e_sel, vq[i].e_cause}));
      check($sformatf("row%0d_cnt", i), 64'(retire_count), 64'(exp_cnt));
      if (vq[i].e_strb[0]) exp_cnt = exp_cnt + 32'd1;
      @(posedge clk);
      #1;
    end

    // Reset mid-instruction: abort in WB with no retire and no PC write
    drive(1,0,OP_REG,0,0,0); tick();
    drive(0,0,OP_REG,1,0,0); tick();
    drive(0,0,OP_REG,0,0,0); tick();
    tick();
    check("pre_rst_state", 64'(state), 64'd5);
    rst = 1'b1;
    #1;
    check("rst_abort_state", 64'(state), 64'd0);
    check("rst_abort_strb", 64'(strb), 64'd0);
    check("rst_abort_cnt", 64'(retire_count), 64'd0);
    tick();
    check("rst_hold_ctl", 64'({state, strb, pc_sel, trap_cause}), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle%0d", k), 64'({state, busy}), 64'd0);
      @(posedge clk);
      #1;
    end

    // Retire counter wrap, with halt in WB returning to IDLE
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    drive(1,0,OP_REG,0,0,0); tick();
    drive(0,0,OP_REG,1,0,0); tick();
    drive(0,0,OP_REG,0,0,0); tick();
    tick();
    drive(0,1,OP_REG,0,0,0);
    @(negedge clk);
    check("wrap_pre_cnt", 64'(retire_count), 64'hFFFF_FFFF);
    check("wrap_wb_strb", 64'({state, strb}), 64'({3'd5, WBR}));
    @(posedge clk);
    #1;
    drive(0,0,OP_REG,0,0,0);
    check("wrap_cnt", 64'(retire_count), 64'd0);
    check("halt_idle", 64'({state, busy}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
